// File: rtl/ysyx_23060020_mem_arbiter.sv
// Two-master (IFU = m0, LSU = m1), one-slave memory arbiter with one outstanding transaction.
// Define ARB_RR_EN for round-robin ties; otherwise m1 (LSU) wins every tie.
module ysyx_23060020_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                m0_req_valid,
    output logic                m0_req_ready,
    input  logic [ADDR_W-1:0]   m0_req_addr,
    output logic                m0_resp_valid,
    input  logic                m0_resp_ready,
    output logic [DATA_W-1:0]   m0_resp_rdata,
    input  logic                m1_req_valid,
    output logic                m1_req_ready,
    input  logic [ADDR_W-1:0]   m1_req_addr,
    input  logic                m1_req_wen,
    input  logic [DATA_W-1:0]   m1_req_wdata,
    input  logic [DATA_W/8-1:0] m1_req_wmask,
    output logic                m1_resp_valid,
    input  logic                m1_resp_ready,
    output logic [DATA_W-1:0]   m1_resp_rdata,
    output logic                s_req_valid,
    input  logic                s_req_ready,
    output logic [ADDR_W-1:0]   s_req_addr,
    output logic                s_req_wen,
    output logic [DATA_W-1:0]   s_req_wdata,
    output logic [DATA_W/8-1:0] s_req_wmask,
    input  logic                s_resp_valid,
    output logic                s_resp_ready,
    input  logic [DATA_W-1:0]   s_resp_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   gnt_q, gnt_d;
    logic   last_gnt_q, last_gnt_d;
    logic   arb_pick;
    logic   req_hs;
    logic   resp_hs;
    logic   gnt_resp_ready;

    // arb_pick is the master chosen if arbitration happens this cycle (1 = m1).
    always_comb begin
`ifdef ARB_RR_EN
        if (m0_req_valid && m1_req_valid) begin
            arb_pick = ~last_gnt_q;
        end else begin
            arb_pick = m1_req_valid;
        end
`else
        arb_pick = m1_req_valid;
`endif
    end

    always_comb begin
        gnt_resp_ready = gnt_q ? m1_resp_ready : m0_resp_ready;
        req_hs         = (state_q == REQ) && s_req_ready;
        resp_hs        = (state_q == RESP) && s_resp_valid && gnt_resp_ready;
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                if (m0_req_valid || m1_req_valid) begin
                    gnt_d   = arb_pick;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (req_hs) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_hs) begin
                    last_gnt_d = gnt_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // Payload and handshakes are steered from the frozen grant; everything idles at 0.
    always_comb begin
        m0_req_ready  = 1'b0;
        m1_req_ready  = 1'b0;
        m0_resp_valid = 1'b0;
        m1_resp_valid = 1'b0;
        m0_resp_rdata = '0;
        m1_resp_rdata = '0;
        s_req_valid   = 1'b0;
        s_req_addr    = '0;
        s_req_wen     = 1'b0;
        s_req_wdata   = '0;
        s_req_wmask   = '0;
        s_resp_ready  = 1'b0;
        case (state_q)
            REQ: begin
                s_req_valid = 1'b1;
                if (gnt_q) begin
                    s_req_addr   = m1_req_addr;
                    s_req_wen    = m1_req_wen;
                    s_req_wdata  = m1_req_wdata;
                    s_req_wmask  = m1_req_wmask;
                    m1_req_ready = s_req_ready;
                end else begin
                    s_req_addr   = m0_req_addr;
                    m0_req_ready = s_req_ready;
                end
            end
            RESP: begin
                s_resp_ready = gnt_resp_ready;
                if (gnt_q) begin
                    m1_resp_valid = s_resp_valid;
                    m1_resp_rdata = s_resp_rdata;
                end else begin
                    m0_resp_valid = s_resp_valid;
                    m0_resp_rdata = s_resp_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060020_mem_arbiter.sv
// Directed bench for the two-master memory arbiter; the slave side is driven by the tasks.
module tb_ysyx_23060020_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req_valid, m0_req_ready, m0_resp_valid, m0_resp_ready;
    logic [31:0] m0_req_addr, m0_resp_rdata;
    logic        m1_req_valid, m1_req_ready, m1_req_wen, m1_resp_valid, m1_resp_ready;
    logic [31:0] m1_req_addr, m1_req_wdata, m1_resp_rdata;
    logic [3:0]  m1_req_wmask;
    logic        s_req_valid, s_req_ready, s_req_wen, s_resp_valid, s_resp_ready;
    logic [31:0] s_req_addr, s_req_wdata, s_resp_rdata;
    logic [3:0]  s_req_wmask;

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;

    ysyx_23060020_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
        .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready), .m0_resp_rdata(m0_resp_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
        .m1_req_wen(m1_req_wen), .m1_req_wdata(m1_req_wdata), .m1_req_wmask(m1_req_wmask),
        .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready), .m1_resp_rdata(m1_resp_rdata),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
        .s_req_wen(s_req_wen), .s_req_wdata(s_req_wdata), .s_req_wmask(s_req_wmask),
        .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_resp_rdata(s_resp_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rst_n && s_resp_valid && s_resp_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_req_valid = 0; m0_req_addr = 0; m0_resp_ready = 0;
        m1_req_valid = 0; m1_req_addr = 0; m1_req_wen = 0; m1_req_wdata = 0; m1_req_wmask = 0;
        m1_resp_ready = 0;
        s_req_ready = 0; s_resp_valid = 0; s_resp_rdata = 0;
    endtask

    task automatic pulse_reset();
        rst_n = 0;
        #2;
        clear_inputs();
        step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        total++;
        if ({s_req_valid, s_resp_ready, m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid, s_req_wen} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0", {s_req_valid, s_resp_ready, m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid, s_req_wen});
        end
        total++;
        if ({s_req_addr, s_req_wdata, s_req_wmask, m0_resp_rdata, m1_resp_rdata} !== 132'b0) begin
            bad++;
            $display("FAIL reset_data: addr=%h wdata=%h wmask=%h r0=%h r1=%h want 0", s_req_addr, s_req_wdata, s_req_wmask, m0_resp_rdata, m1_resp_rdata);
        end
    endtask

    task automatic test_single_read();
        m0_req_valid = 1; m0_req_addr = 32'h8000_0000; s_req_ready = 1;
        total++;
        if (s_req_valid !== 1'b0) begin bad++; $display("FAIL read_c0_idle: s_req_valid=%b want 0", s_req_valid); end
        step();
        total++;
        if ({s_req_valid, m0_req_ready, s_req_wen, s_req_addr} !== {3'b110, 32'h8000_0000}) begin
            bad++; $display("FAIL read_c1_req: v=%b rdy=%b wen=%b addr=%h want 1 1 0 80000000", s_req_valid, m0_req_ready, s_req_wen, s_req_addr);
        end
        total++;
        if ({m1_req_ready, m1_resp_valid, m1_resp_rdata} !== 34'b0) begin bad++; $display("FAIL read_c1_m1: got %h want 0", {m1_req_ready, m1_resp_valid, m1_resp_rdata}); end
        step();
        m0_req_valid = 0; s_req_ready = 0; s_resp_valid = 1; s_resp_rdata = 32'h0000_0413; m0_resp_ready = 1;
        #1;
        total++;
        if ({m0_resp_valid, s_resp_ready, m0_resp_rdata} !== {2'b11, 32'h0000_0413}) begin
            bad++; $display("FAIL read_c2_resp: v=%b rdy=%b rdata=%h want 1 1 00000413", m0_resp_valid, s_resp_ready, m0_resp_rdata);
        end
        total++;
        if ({m1_req_ready, m1_resp_valid, m1_resp_rdata} !== 34'b0) begin bad++; $display("FAIL read_c2_m1: got %h want 0", {m1_req_ready, m1_resp_valid, m1_resp_rdata}); end
        step();
        s_resp_valid = 0; m0_resp_ready = 0;
        #1;
        total++;
        if ({s_req_valid, m0_resp_valid, s_resp_ready, m1_req_ready, m1_resp_valid} !== 5'b0) begin
            bad++; $display("FAIL read_c3_idle: got %b want 0", {s_req_valid, m0_resp_valid, s_resp_ready, m1_req_ready, m1_resp_valid});
        end
    endtask

    task automatic test_lsu_write();
        int pulses = 0;
        m1_req_valid = 1; m1_req_addr = 32'h8000_1000; m1_req_wdata = 32'hDEAD_BEEF;
        m1_req_wmask = 4'hF; m1_req_wen = 1; s_req_ready = 1; m1_resp_ready = 1;
        step();
        total++;
        if ({s_req_valid, s_req_wen, m1_req_ready, s_req_addr, s_req_wdata, s_req_wmask} !== {3'b111, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF}) begin
            bad++; $display("FAIL write_fields: v=%b wen=%b rdy=%b addr=%h wdata=%h wmask=%h want 1 1 1 80001000 deadbeef f",
                            s_req_valid, s_req_wen, m1_req_ready, s_req_addr, s_req_wdata, s_req_wmask);
        end
        total++;
        if ({m0_req_ready, m0_resp_valid} !== 2'b00) begin bad++; $display("FAIL write_m0_quiet: got %b want 00", {m0_req_ready, m0_resp_valid}); end
        if (m1_resp_valid) pulses++;
        step();
        m1_req_valid = 0; m1_req_wen = 0; s_req_ready = 0; s_resp_valid = 1; s_resp_rdata = 32'h1234_5678;
        #1;
        if (m1_resp_valid) pulses++;
        step();
        s_resp_valid = 0; m1_resp_ready = 0;
        #1;
        if (m1_resp_valid) pulses++;
        total++;
        if (pulses !== 1) begin bad++; $display("FAIL write_resp_pulse: got %0d pulses want 1", pulses); end
    endtask

    task automatic test_arbitration();
        logic exp_gnt [4];
        logic got;
`ifdef ARB_RR_EN
        exp_gnt = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_gnt = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            m0_req_valid = 1; m1_req_valid = 1; m0_req_addr = 32'h8000_0010; m1_req_addr = 32'h8000_2000;
            s_req_ready = 1; m0_resp_ready = 1; m1_resp_ready = 1;
            step();
            got = m1_req_ready;
            total++;
            if ((m0_req_ready ^ m1_req_ready) !== 1'b1 || got !== exp_gnt[i]) begin
                bad++; $display("FAIL arb_gnt%0d: m0_rdy=%b m1_rdy=%b want gnt m%0d", i, m0_req_ready, m1_req_ready, exp_gnt[i]);
            end
            step();
            if (got) m1_req_valid = 0; else m0_req_valid = 0;
            s_req_ready = 0; s_resp_valid = 1;
            step();
            s_resp_valid = 0;
        end
        clear_inputs();
    endtask

    task automatic test_stalls();
        int hs0;
        hs0 = hs_cnt;
        m0_req_valid = 1; m0_req_addr = 32'h8000_0040; s_req_ready = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({s_req_valid, m0_req_ready, s_resp_ready} !== 3'b100) begin
                bad++; $display("FAIL stall_req%0d: v=%b rdy=%b srr=%b want 1 0 0", i, s_req_valid, m0_req_ready, s_resp_ready);
            end
            if (i == 4) s_req_ready = 1;
            step();
        end
        m0_req_valid = 0; s_req_ready = 0; s_resp_valid = 1; s_resp_rdata = 32'hCAFE_0001; m0_resp_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({s_req_valid, m0_resp_valid, s_resp_ready} !== 3'b010) begin
                bad++; $display("FAIL stall_resp%0d: sv=%b rv=%b srr=%b want 0 1 0", i, s_req_valid, m0_resp_valid, s_resp_ready);
            end
            step();
        end
        m0_resp_ready = 1;
        #1;
        total++;
        if ({m0_resp_valid, s_resp_ready, m0_resp_rdata} !== {2'b11, 32'hCAFE_0001}) begin
            bad++; $display("FAIL stall_release: v=%b rdy=%b rdata=%h want 1 1 cafe0001", m0_resp_valid, s_resp_ready, m0_resp_rdata);
        end
        step();
        s_resp_valid = 0; m0_resp_ready = 0;
        step();
        total++;
        if (hs_cnt - hs0 !== 1) begin bad++; $display("FAIL stall_hs_count: got %0d want 1", hs_cnt - hs0); end
    endtask

    task automatic test_back_to_back();
        m0_req_valid = 1; m0_req_addr = 32'h8000_0080; s_req_ready = 1; m0_resp_ready = 1;
        s_resp_valid = 1; s_resp_rdata = 32'h5555_AAAA;
        step();
        total++;
        if ({s_req_valid, m0_req_ready, m0_resp_valid, s_resp_ready} !== 4'b1100) begin
            bad++; $display("FAIL b2b_early_resp: got %b want 1100", {s_req_valid, m0_req_ready, m0_resp_valid, s_resp_ready});
        end
        step();
        total++;
        if ({m0_resp_valid, m0_resp_rdata} !== {1'b1, 32'h5555_AAAA}) begin
            bad++; $display("FAIL b2b_resp1: v=%b rdata=%h want 1 5555aaaa", m0_resp_valid, m0_resp_rdata);
        end
        step();
        total++;
        if ({s_req_valid, m0_resp_valid} !== 2'b00) begin bad++; $display("FAIL b2b_idle_gap: got %b want 00", {s_req_valid, m0_resp_valid}); end
        step();
        total++;
        if ({s_req_valid, m0_req_ready} !== 2'b11) begin bad++; $display("FAIL b2b_second_req: got %b want 11", {s_req_valid, m0_req_ready}); end
        m0_req_valid = 0;
        step();
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        m0_req_valid = 1; m0_req_addr = 32'h8000_00C0; s_req_ready = 1;
        step();
        m0_req_valid = 0; s_req_ready = 0; s_resp_valid = 1; s_resp_rdata = 32'h7777_7777; m0_resp_ready = 1;
        step();
        #2;
        rst_n = 0;
        #1;
        total++;
        if ({s_req_valid, s_resp_ready, m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid, m0_resp_rdata} !== 38'b0) begin
            bad++; $display("FAIL rst_mid_outputs: v=%b srr=%b rv=%b rdata=%h want 0", s_req_valid, s_resp_ready, m0_resp_valid, m0_resp_rdata);
        end
        clear_inputs();
        step();
        rst_n = 1;
        m0_req_valid = 1; m0_req_addr = 32'h8000_0100; s_req_ready = 1;
        step();
        total++;
        if ({s_req_valid, m0_req_ready, s_req_addr} !== {2'b11, 32'h8000_0100}) begin
            bad++; $display("FAIL rst_mid_regrant: v=%b rdy=%b addr=%h want 1 1 80000100", s_req_valid, m0_req_ready, s_req_addr);
        end
        m0_req_valid = 0;
        step();
        s_resp_valid = 1; m0_resp_ready = 1;
        step();
        clear_inputs();
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        #3;
        test_reset();
        step();
        rst_n = 1;
        test_single_read();
        test_lsu_write();
        test_arbitration();
        test_stalls();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
